// File: rtl/alu_arbiter_ctrl.sv
// Two-requester round-robin front end for a fixed-latency ALU: grants one command,
// holds it on the ALU for ALU_LAT cycles, then presents the result until consumed.
module alu_arbiter_ctrl #(
    parameter int unsigned ALU_LAT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [3:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       req1_ready,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_cout,
    output logic       rsp_of,
    output logic       alu_enable,
    output logic [3:0] alu_opcode,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_out,
    input  logic       alu_cout,
    input  logic       alu_of,
    output logic       busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0] r_state;
    logic       r_last;
    logic       r_gnt;
    logic [3:0] r_cnt;
    logic [3:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [7:0] r_data;
    logic       r_cout;
    logic       r_of;

    logic w_idle;
    logic w_any;
    logic w_gnt;
    logic w_rsp_ack;

    assign w_idle    = (r_state == S_IDLE);
    assign w_any     = req0_valid | req1_valid;
    // Under contention the requester that did not win last time goes next.
    assign w_gnt     = (req0_valid && req1_valid) ? ~r_last : req1_valid;
    assign w_rsp_ack = r_gnt ? rsp1_ready : rsp0_ready;

    // Ready is combinational, so it is gated by reset to stay low while reset is held.
    assign req0_ready = reset & w_idle & w_any & ~w_gnt;
    assign req1_ready = reset & w_idle & w_any & w_gnt;

    assign busy       = ~w_idle;
    assign alu_enable = ~w_idle;
    assign alu_opcode = r_op;
    assign alu_a      = r_a;
    assign alu_b      = r_b;

    assign rsp0_valid = (r_state == S_RESP) & ~r_gnt;
    assign rsp1_valid = (r_state == S_RESP) & r_gnt;
    assign rsp_data   = r_data;
    assign rsp_cout   = r_cout;
    assign rsp_of     = r_of;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_gnt   <= 1'b0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_data  <= '0;
            r_cout  <= 1'b0;
            r_of    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_gnt;
                        r_last  <= w_gnt;
                        r_op    <= w_gnt ? req1_op : req0_op;
                        r_a     <= w_gnt ? req1_a  : req0_a;
                        r_b     <= w_gnt ? req1_b  : req0_b;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= 4'(ALU_LAT - 1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_data  <= alu_out;
                        r_cout  <= alu_cout;
                        r_of    <= alu_of;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (w_rsp_ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Bench for alu_arbiter_ctrl: a behavioural ALU plus arbitration/latency model for the
// main instance, and counter-driven ALUs on three extra instances for the latency sweep.
module tb_alu_arbiter_ctrl;

    localparam int unsigned LAT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [7:0] rsp_data;
    logic       rsp_cout, rsp_of;
    logic       alu_enable;
    logic [3:0] alu_opcode;
    logic [7:0] alu_a, alu_b, alu_out;
    logic       alu_cout, alu_of, busy;

    logic [15:0] cyc = '0;
    int n_tests = 0;
    int n_fail  = 0;
    bit ref_last;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 16'd1;

    // Behavioural ALU: returns {of, cout, data}.
    function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic       of;
        case (op)
            4'h0, 4'h2: begin s = {1'b0, a} + {1'b0, b}; of = (a[7] == b[7]) && (s[7] != a[7]); end
            4'h1:       begin s = {1'b0, a} - {1'b0, b}; of = (a[7] != b[7]) && (s[7] != a[7]); end
            4'h3:       begin s = {1'b0, a & b}; of = 1'b0; end
            4'h4:       begin s = {1'b0, a | b}; of = 1'b0; end
            4'h5:       begin s = {1'b0, a ^ b}; of = 1'b0; end
            default:    begin s = {1'b0, 8'(a + b + {4'h0, op})}; of = 1'b0; end
        endcase
        return {of, s[8], s[7:0]};
    endfunction

    assign {alu_of, alu_cout, alu_out} = alu_fn(alu_opcode, alu_a, alu_b);

    alu_arbiter_ctrl #(.ALU_LAT(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_cout(rsp_cout), .rsp_of(rsp_of),
        .alu_enable(alu_enable), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_of(alu_of), .busy(busy)
    );

    // Latency-sweep instances: the ALU result is the free-running cycle count.
    logic       sw_v[3], sw_rr[3], sw_rdy[3], sw_rdy1[3], sw_rv[3], sw_rv1[3];
    logic       sw_co[3], sw_of[3], sw_en[3], sw_busy[3];
    logic [7:0] sw_data[3], sw_aa[3], sw_ab[3];
    logic [3:0] sw_op[3];

    for (genvar k = 0; k < 3; k++) begin : g_sweep
        alu_arbiter_ctrl #(.ALU_LAT(k == 0 ? 1 : (k == 1 ? 4 : 15))) u_sw (
            .clk(clk), .reset(reset),
            .req0_valid(sw_v[k]), .req0_op(4'h0), .req0_a(8'h00), .req0_b(8'h00), .req0_ready(sw_rdy[k]),
            .req1_valid(1'b0), .req1_op(4'h0), .req1_a(8'h00), .req1_b(8'h00), .req1_ready(sw_rdy1[k]),
            .rsp0_valid(sw_rv[k]), .rsp0_ready(sw_rr[k]), .rsp1_valid(sw_rv1[k]), .rsp1_ready(1'b0),
            .rsp_data(sw_data[k]), .rsp_cout(sw_co[k]), .rsp_of(sw_of[k]),
            .alu_enable(sw_en[k]), .alu_opcode(sw_op[k]), .alu_a(sw_aa[k]), .alu_b(sw_ab[k]),
            .alu_out(cyc[7:0]), .alu_cout(cyc[8]), .alu_of(cyc[9]), .busy(sw_busy[k])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full command: grant check, ISSUE/WAIT hold checks, RESP with back-pressure, release.
    task automatic txn(input bit v0, input bit v1, input logic [1:0] hold, input int unsigned bp,
                       input bit pulse1, input bit fixed);
        logic [3:0] op[2];
        logic [7:0] a[2], b[2];
        logic [9:0] exp;
        int         g;
        for (int i = 0; i < 2; i++) begin
            op[i] = 4'($urandom); a[i] = 8'($urandom); b[i] = 8'($urandom);
        end
        if (fixed) begin op[0] = 4'h2; a[0] = 8'h7F; b[0] = 8'h01; end
        g = (v0 && v1) ? int'(!ref_last) : (v1 ? 1 : 0);
        ref_last = (g == 1);
        exp = alu_fn(op[g], a[g], b[g]);
        req0_valid = v0; req0_op = op[0]; req0_a = a[0]; req0_b = b[0];
        req1_valid = v1; req1_op = op[1]; req1_a = a[1]; req1_b = b[1];
        #1;
        chk("grant_r0", req0_ready, 32'(g == 0));
        chk("grant_r1", req1_ready, 32'(g == 1));
        tick();
        req0_valid = hold[0]; req1_valid = hold[1];
        req0_op = 4'($urandom); req0_a = 8'($urandom); req1_b = 8'($urandom);
        for (int c = 0; c <= int'(LAT); c++) begin
            if (pulse1) req1_valid = (c == 2);
            #1;
            chk("busy", busy, 1);
            chk("alu_en", alu_enable, 1);
            chk("alu_op", alu_opcode, op[g]);
            chk("alu_a", alu_a, a[g]);
            chk("alu_b", alu_b, b[g]);
            chk("rdy0_busy", req0_ready, 0);
            chk("rdy1_busy", req1_ready, 0);
            chk("early_rsp", 32'({rsp1_valid, rsp0_valid}), 0);
            tick();
        end
        req1_valid = hold[1];
        for (int n = 0; n <= int'(bp); n++) begin
            chk("rsp0_valid", rsp0_valid, 32'(g == 0));
            chk("rsp1_valid", rsp1_valid, 32'(g == 1));
            chk("rsp_data", rsp_data, exp[7:0]);
            chk("rsp_cout", rsp_cout, exp[8]);
            chk("rsp_of", rsp_of, exp[9]);
            chk("alu_op_resp", alu_opcode, op[g]);
            chk("rdy_resp", 32'({req1_ready, req0_ready}), 0);
            if (n == int'(bp)) begin
                rsp0_ready = (g == 0); rsp1_ready = (g == 1);
            end else begin
                rsp0_ready = (g == 1); rsp1_ready = (g == 0);
            end
            tick();
        end
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_en", alu_enable, 0);
        chk("idle_rsp", 32'({rsp1_valid, rsp0_valid}), 0);
    endtask

    task automatic sweep();
        int unsigned lat, g_cyc, n;
        logic [15:0] v;
        for (int k = 0; k < 3; k++) begin
            lat = (k == 0) ? 1 : ((k == 1) ? 4 : 15);
            sw_v[k] = 1'b1;
            #1;
            chk("sw_grant", sw_rdy[k], 1);
            g_cyc = int'(cyc);
            tick();
            sw_v[k] = 1'b0;
            n = 1;
            while (n < 40 && !sw_rv[k]) begin
                tick();
                n++;
            end
            v = 16'(g_cyc + 1 + lat);
            chk("sw_latency", n, lat + 2);
            chk("sw_data", sw_data[k], v[7:0]);
            chk("sw_cout", sw_co[k], v[8]);
            chk("sw_of", sw_of[k], v[9]);
            sw_rr[k] = 1'b1;
            tick();
            sw_rr[k] = 1'b0;
            chk("sw_done", 32'({sw_busy[k], sw_rv[k]}), 0);
        end
    endtask

    initial begin
        int unsigned r;
        reset = 1'b0; ref_last = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_op = 4'hF; req0_a = 8'hFF; req0_b = 8'hFF;
        req1_op = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin sw_v[k] = 1'b0; sw_rr[k] = 1'b0; end
        #2;
        chk("rst_ready", 32'({req1_ready, req0_ready}), 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu", 32'({alu_enable, alu_opcode, alu_a, alu_b}), 0);
        chk("rst_rsp", 32'({rsp1_valid, rsp0_valid, rsp_cout, rsp_of, rsp_data}), 0);
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
        repeat (2) begin
            chk("idle_stay", busy, 0);
            tick();
        end

        txn(1'b1, 1'b0, 2'b00, 0, 1'b0, 1'b1);
        txn(1'b0, 1'b1, 2'b01, 20, 1'b0, 1'b0);
        repeat (4) txn(1'b1, 1'b1, 2'b11, 1, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 2'b00, 0, 1'b1, 1'b0);
        txn(1'b0, 1'b1, 2'b00, 0, 1'b0, 1'b0);

        // Abort during WAIT.
        req0_valid = 1'b1; req0_op = 4'h3; req0_a = 8'h5A; req0_b = 8'hC3;
        #1;
        chk("pre_rst_grant", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        tick(); tick();
        chk("pre_rst_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_busy", 32'({busy, alu_enable}), 0);
        chk("async_alu", 32'({alu_opcode, alu_a, alu_b}), 0);
        chk("async_rsp", 32'({rsp1_valid, rsp0_valid, rsp_cout, rsp_of, rsp_data}), 0);
        ref_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
        repeat (8) begin
            chk("post_rst_rsp", 32'({rsp1_valid, rsp0_valid, busy}), 0);
            tick();
        end
        txn(1'b1, 1'b1, 2'b00, 0, 1'b0, 1'b0);

        repeat (20) begin
            r = $urandom_range(1, 3);
            txn(r[0], r[1], 2'($urandom), $urandom_range(0, 3), 1'b0, 1'b0);
        end

        sweep();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter_ctrl.md
ALU_ARBITER_CTRL -- requirements
Module: alu_arbiter_ctrl

Interface
REQ-001 Parameter: ALU_LAT, 4, cycles from the ALU operand-presentation edge to a valid ALU result; legal range 1-15.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Ports: req0_valid / req1_valid  input  1  requester N has a command pending.
REQ-005 Ports: req0_op / req1_op  input  4  ALU opcode from requester N.
REQ-006 Ports: req0_a, req0_b / req1_a, req1_b  input  8  operands from requester N.
REQ-007 Ports: req0_ready / req1_ready  output  1  command from requester N is accepted this cycle.
REQ-008 Ports: rsp0_valid / rsp1_valid  output  1  result for requester N is available.
REQ-009 Ports: rsp0_ready / rsp1_ready  input  1  requester N consumes its result.
REQ-010 Ports: rsp_data  output  8  result; rsp_cout  output  1  carry; rsp_of  output  1  overflow; all three are shared by both responses.
REQ-011 Ports: alu_enable  output  1; alu_opcode  output  4; alu_a, alu_b  output  8; these drive the ALU.
REQ-012 Ports: alu_out  input  8; alu_cout  input  1; alu_of  input  1; these are the ALU results.
REQ-013 Port: busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-015 IDLE: if any reqN_valid is high, the block SHALL grant one requester, assert that requester's reqN_ready for exactly that cycle, latch its op/a/b, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin with a 1-bit last-grant pointer (reset value: last=1, so requester 0 wins first).
REQ-017 When only one requester is valid, that requester SHALL be granted.
REQ-018 When both requesters are valid, the requester not equal to last SHALL be granted; last SHALL update on each grant.
REQ-019 ISSUE: the block SHALL drive the latched op/a/b onto alu_opcode/alu_a/alu_b, assert alu_enable, load a 4-bit wait counter with ALU_LAT-1, and go to WAIT.
REQ-020 alu_opcode/alu_a/alu_b SHALL remain stable from ISSUE until RESP is exited.
REQ-021 alu_enable SHALL stay high from ISSUE until RESP is exited.
REQ-022 WAIT: the counter SHALL decrement each cycle; when the counter is 0, the block SHALL capture alu_out/alu_cout/alu_of into the response registers and go to RESP.
REQ-023 The capture SHALL happen exactly ALU_LAT cycles after the ISSUE cycle.
REQ-024 RESP: the block SHALL assert rspN_valid only for the granted requester, with rsp_data/rsp_cout/rsp_of held constant.
REQ-025 RESP: on a cycle where rspN_ready is high, the block SHALL deassert rspN_valid on the next edge and go to IDLE.
REQ-026 Back-pressure: RESP SHALL hold indefinitely while rspN_ready is low.
REQ-027 rspM_ready for the non-granted requester SHALL be ignored.
REQ-028 The block SHALL allow only one operation in flight.
REQ-029 reqN_ready SHALL be low in ISSUE, WAIT and RESP.
REQ-030 Minimum command-to-command spacing SHALL be ALU_LAT+3 cycles.
REQ-031 A reqN_valid that drops before its grant SHALL be discarded, with no side effects.
REQ-032 Only one reqN_ready SHALL be asserted in any cycle.
REQ-033 No arithmetic SHALL be performed on operands; opcode and operands SHALL pass through unmodified.
REQ-034 Opcodes outside the ALU decode SHALL be issued unchanged.

Reset
REQ-035 On reset low, the block SHALL asynchronously force: state=IDLE; last=1; counter=0; all outputs 0 (reqN_ready, rspN_valid, rsp_data, rsp_cout, rsp_of, alu_enable, alu_opcode, alu_a, alu_b, busy).
REQ-036 Reset asserted mid-operation (ISSUE, WAIT or RESP) SHALL abort the operation; no response SHALL be delivered after reset is released.
REQ-037 After reset is released, the first grant SHALL occur no earlier than the first rising edge following release.

Verification
REQ-038 Single op: req0 op=4'h2 a=8'h7F b=8'h01, ALU_LAT=4, ALU model returns 8'h80 cout=0 of=1 -> req0_ready pulses 1 cycle; rsp0_valid rises 6 cycles after grant; rsp_data=8'h80, rsp_of=1.
REQ-039 Contention: req0 and req1 both held valid continuously -> grants alternate 0,1,0,1; each rspN_valid goes only to the granted requester.
REQ-040 Back-pressure: rsp1_ready held low for 20 cycles -> rsp1_valid and rsp_data stay stable; req0_ready stays 0 throughout; the next grant comes 1 cycle after rsp1_ready rises.
REQ-041 Reset mid-WAIT: reset low during WAIT -> all outputs 0 immediately (asynchronous); no rsp valid after release; the next grant goes to req0.
REQ-042 Latency sweep: ALU_LAT in {1, 4, 15} with a counter-driven ALU model -> the captured value equals the model output at exactly ALU_LAT cycles after ISSUE.
REQ-043 Withdrawn request: req1_valid pulses 1 cycle while the block is in WAIT -> no grant to requester 1; the block returns to IDLE with no stray response.
